// File: rtl/rv32i_run_ctrl_if.sv
// Core-facing bundle between the run controller and the controlled rv32i core.
// The controller watches the retire stream and owns the core reset.
interface rv32i_run_ctrl_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        core_rst;

  modport master (
    input  pc,
    input  instr,
    input  instr_valid,
    output core_rst
  );

  modport slave (
    output pc,
    output instr,
    output instr_valid,
    input  core_rst
  );
endinterface

// File: rtl/rv32i_run_ctrl.sv
// Launch/supervise controller for an rv32i core: holds the core in reset for
// RST_CYCLES after start, lets it run, and halts on ecall/ebreak, a pc
// self-loop or a cycle budget timeout.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | post-reset, core held in reset, waiting for start
// S_RESET | core reset pulse, down-counter from RST_CYCLES-1 to 0
// S_RUN   | core running, counting cycles/instructions, halt detect
// S_DONE  | halted, results frozen until the next start
module rv32i_run_ctrl #(
  parameter int RST_CYCLES  = 4,
  parameter int MAX_CYCLES  = 500,
  parameter int STALL_LIMIT = 8,
  parameter int CW          = $clog2(MAX_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  rv32i_run_ctrl_if.master       core_if,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [1:0]             halt_cause_o,
  output logic [CW-1:0]          cycle_count_o,
  output logic [31:0]            instr_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0]   ECALL     = 32'h0000_0073;
  localparam logic [31:0]   EBREAK    = 32'h0010_0073;
  localparam logic [7:0]    RST_LOAD  = 8'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(MAX_CYCLES - 1);
  // STALL_LIMIT counts cycles spent at one pc, so the halt fires on the
  // (STALL_LIMIT-1)th consecutive match; the counter holds matches so far.
  localparam logic [7:0]    STALL_HIT = 8'(STALL_LIMIT - 2);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_SYS   = 2'b01;
  localparam logic [1:0] CAUSE_LOOP  = 2'b10;
  localparam logic [1:0] CAUSE_TMO   = 2'b11;

  state_t        state_q, state_d;
  logic [7:0]    rst_cnt_q, rst_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [31:0]   icnt_q, icnt_d;
  logic [7:0]    stall_q, stall_d;
  logic [31:0]   prev_pc_q, prev_pc_d;
  logic          prev_vld_q, prev_vld_d;
  logic [1:0]    cause_q, cause_d;

  logic          is_sys;
  logic          pc_match;
  logic          stall_hit;
  logic          tmo_hit;

  // Halt-condition decode for the current RUN cycle.
  always_comb begin
    is_sys    = core_if.instr_valid &&
                ((core_if.instr == ECALL) || (core_if.instr == EBREAK));
    // prev_vld_q is clear on the first RUN cycle so no RESET-time pc is compared.
    pc_match  = prev_vld_q && (core_if.pc == prev_pc_q);
    stall_hit = pc_match && (stall_q == STALL_HIT);
    tmo_hit   = (cyc_q == TMO_LAST);
  end

  // Next-state and counter update.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    cyc_d      = cyc_q;
    icnt_d     = icnt_q;
    stall_d    = stall_q;
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;
    cause_d    = cause_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_RESET;
          rst_cnt_d  = RST_LOAD;
          cyc_d      = '0;
          icnt_d     = '0;
          stall_d    = '0;
          prev_vld_d = 1'b0;
          cause_d    = CAUSE_NONE;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == 8'd0) state_d = S_RUN;
        else                   rst_cnt_d = rst_cnt_q - 8'd1;
      end
      S_RUN: begin
        if (core_if.instr_valid && (icnt_q != 32'hFFFF_FFFF)) icnt_d = icnt_q + 32'd1;
        prev_pc_d  = core_if.pc;
        prev_vld_d = 1'b1;
        stall_d    = pc_match ? (stall_q + 8'd1) : 8'd0;
        if (is_sys)         cause_d = CAUSE_SYS;
        else if (stall_hit) cause_d = CAUSE_LOOP;
        else if (tmo_hit)   cause_d = CAUSE_TMO;
        // cycle_count freezes on the halting edge, so it reads the detecting cycle.
        if (is_sys || stall_hit || tmo_hit) state_d = S_DONE;
        else                                cyc_d   = cyc_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rst_cnt_q  <= '0;
      cyc_q      <= '0;
      icnt_q     <= '0;
      stall_q    <= '0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cyc_q      <= cyc_d;
      icnt_q     <= icnt_d;
      stall_q    <= stall_d;
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
      cause_q    <= cause_d;
    end
  end

  assign core_if.core_rst = (state_q != S_RUN);
  assign busy_o           = (state_q == S_RESET) || (state_q == S_RUN);
  assign done_o           = (state_q == S_DONE);
  assign halt_cause_o     = cause_q;
  assign cycle_count_o    = cyc_q;
  assign instr_count_o    = icnt_q;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Bench for rv32i_run_ctrl: a default instance plus a MAX_CYCLES=20 instance,
// random retire streams scored against a run-length based reference model.
module tb_rv32i_run_ctrl;
  localparam int STALL = 8;
  localparam int RSTC  = 4;
  localparam int NARR  = 700;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_s = 1'b0;
  logic [31:0] pc_drv = '0, instr_drv = '0;
  logic vld_drv = 1'b0;

  rv32i_run_ctrl_if bus_a ();
  rv32i_run_ctrl_if bus_s ();
  assign bus_a.pc = pc_drv;  assign bus_a.instr = instr_drv;  assign bus_a.instr_valid = vld_drv;
  assign bus_s.pc = pc_drv;  assign bus_s.instr = instr_drv;  assign bus_s.instr_valid = vld_drv;

  logic busy_a, done_a, busy_s, done_s;
  logic [1:0] cause_a, cause_s;
  logic [8:0] cyc_a;
  logic [4:0] cyc_s;
  logic [31:0] icnt_a, icnt_s;

  rv32i_run_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .core_if(bus_a.master),
    .busy_o(busy_a), .done_o(done_a), .halt_cause_o(cause_a),
    .cycle_count_o(cyc_a), .instr_count_o(icnt_a));

  rv32i_run_ctrl #(.MAX_CYCLES(20)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(start_s), .core_if(bus_s.master),
    .busy_o(busy_s), .done_o(done_s), .halt_cause_o(cause_s),
    .cycle_count_o(cyc_s), .instr_count_o(icnt_s));

  initial forever #5 clk = ~clk;

  bit sel = 1'b0;
  logic o_core_rst, o_busy, o_done;
  logic [1:0] o_cause;
  logic [31:0] o_cyc, o_icnt;
  always_comb begin
    o_core_rst = sel ? bus_s.core_rst : bus_a.core_rst;
    o_busy     = sel ? busy_s : busy_a;
    o_done     = sel ? done_s : done_a;
    o_cause    = sel ? cause_s : cause_a;
    o_cyc      = sel ? 32'(cyc_s) : 32'(cyc_a);
    o_icnt     = sel ? icnt_s : icnt_a;
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] pc_arr [NARR];
  logic [31:0] instr_arr [NARR];
  bit          vld_arr [NARR];

  int          exp_k;
  logic [1:0]  exp_cause;
  logic [31:0] exp_icnt;

  int          ob_rst_len, ob_halt_k;
  logic [1:0]  ob_cause, ob0_cause;
  logic [31:0] ob_cyc, ob_icnt, ob0_cyc, ob0_icnt;
  bit          ob_cnt_ok, ob_frz_ok;
  logic        ob0_busy, ob0_done;

  // Build one launch's retire stream: pc walks by 4 unless held, optional ecall/ebreak.
  task automatic gen_case(input int sys_at, input bit brk, input int hold_from,
                          input logic [31:0] hold_pc, input bit all_valid);
    logic [31:0] base, r;
    base = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
    for (int k = 0; k < NARR; k++) begin
      r = $urandom;
      pc_arr[k]    = (hold_from >= 0 && k >= hold_from) ? hold_pc : base + 32'(4 * k);
      instr_arr[k] = {r[31:7], 7'h13};
      vld_arr[k]   = all_valid ? 1'b1 : r[0];
      if (!vld_arr[k] && r[1]) instr_arr[k] = 32'h0000_0073;
      if (k == sys_at) begin
        vld_arr[k]   = 1'b1;
        instr_arr[k] = brk ? 32'h0010_0073 : 32'h0000_0073;
      end
    end
  endtask

  // Reference: walk RUN cycles, track same-pc run length, stop at first halt.
  task automatic model(input int max_c);
    int run;
    bit sys;
    run = 0; exp_icnt = '0; exp_k = -1; exp_cause = 2'b00;
    for (int k = 0; k < max_c; k++) begin
      if (k == 0) run = 1;
      else if (pc_arr[k] == pc_arr[k-1]) run = run + 1;
      else run = 1;
      if (vld_arr[k]) exp_icnt = exp_icnt + 32'd1;
      sys = vld_arr[k] && (instr_arr[k] == 32'h0000_0073 || instr_arr[k] == 32'h0010_0073);
      if (sys) exp_cause = 2'b01;
      else if (run >= STALL) exp_cause = 2'b10;
      else if (k == max_c - 1) exp_cause = 2'b11;
      if (exp_cause != 2'b00) begin
        exp_k = k;
        break;
      end
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_s = v; else start_a = v;
  endtask

  // Drive one launch on the selected instance and record what it did.
  task automatic run_launch(input bit pre_started, input bit poke);
    if (!pre_started) begin
      set_start(1'b1); @(posedge clk); #1; set_start(1'b0);
    end
    ob0_busy = o_busy; ob0_done = o_done; ob0_cause = o_cause; ob0_cyc = o_cyc; ob0_icnt = o_icnt;
    ob_rst_len = 0;
    while (o_core_rst && o_busy && ob_rst_len < 300) begin
      ob_rst_len++;
      if (poke && ob_rst_len == 2) set_start(1'b1);
      @(posedge clk); #1; set_start(1'b0);
    end
    ob_halt_k = -1; ob_cnt_ok = 1'b1;
    for (int k = 0; k < NARR; k++) begin
      if (o_cyc != 32'(k) || o_core_rst !== 1'b0) ob_cnt_ok = 1'b0;
      pc_drv = pc_arr[k]; instr_drv = instr_arr[k]; vld_drv = vld_arr[k];
      if (poke && k == 3) set_start(1'b1);
      @(posedge clk); #1; set_start(1'b0);
      if (o_done) begin
        ob_halt_k = k;
        break;
      end
    end
    ob_cause = o_cause; ob_cyc = o_cyc; ob_icnt = o_icnt;
    ob_frz_ok = 1'b1;
    repeat (4) begin
      pc_drv = $urandom; instr_drv = 32'h0000_0073; vld_drv = 1'b1;
      @(posedge clk); #1;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_core_rst !== 1'b1 || o_cause !== ob_cause ||
          o_cyc !== ob_cyc || o_icnt !== ob_icnt) ob_frz_ok = 1'b0;
    end
    vld_drv = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus_a.core_rst, busy_a, done_a, cause_a} !== 5'b10000 || cyc_a !== 9'd0 || icnt_a !== 32'd0) begin
      n_fail++; $display("FAIL reset_a: got rst=%b busy=%b done=%b cause=%b cyc=%0d icnt=%0d want 1 0 0 00 0 0",
                         bus_a.core_rst, busy_a, done_a, cause_a, cyc_a, icnt_a);
    end
    n_checks++;
    if ({bus_s.core_rst, busy_s, done_s, cause_s} !== 5'b10000 || cyc_s !== 5'd0 || icnt_s !== 32'd0) begin
      n_fail++; $display("FAIL reset_s: got rst=%b busy=%b done=%b cause=%b cyc=%0d icnt=%0d want 1 0 0 00 0 0",
                         bus_s.core_rst, busy_s, done_s, cause_s, cyc_s, icnt_s);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_a.core_rst, busy_a, done_a} !== 3'b100) begin
      n_fail++; $display("FAIL idle_hold: got rst/busy/done=%b%b%b want 100", bus_a.core_rst, busy_a, done_a);
    end
  endtask

  task automatic test_timeout();
    sel = 1'b0; #1;
    gen_case(-1, 1'b0, -1, 32'h0, 1'b0); model(500); run_launch(1'b0, 1'b0);
    n_checks++;
    if (ob0_busy !== 1'b1 || ob0_done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_launch: got busy=%b done=%b want 1 0", ob0_busy, ob0_done);
    end
    n_checks++;
    if (ob_rst_len != RSTC) begin
      n_fail++; $display("FAIL timeout_rst_len: got %0d want %0d", ob_rst_len, RSTC);
    end
    n_checks++;
    if (ob_halt_k != exp_k || ob_cause !== 2'b11 || ob_cyc !== 32'd499) begin
      n_fail++; $display("FAIL timeout_halt: got k=%0d cause=%b cyc=%0d want k=%0d cause=11 cyc=499",
                         ob_halt_k, ob_cause, ob_cyc, exp_k);
    end
    n_checks++;
    if (ob_icnt !== exp_icnt) begin
      n_fail++; $display("FAIL timeout_icnt: got %0d want %0d", ob_icnt, exp_icnt);
    end
    n_checks++;
    if (!ob_cnt_ok || !ob_frz_ok) begin
      n_fail++; $display("FAIL timeout_count_freeze: got cnt_ok=%0d frz_ok=%0d want 1 1", ob_cnt_ok, ob_frz_ok);
    end
  endtask

  task automatic test_ecall();
    sel = 1'b0; #1;
    gen_case(20, 1'b0, -1, 32'h0, 1'b1); model(500); run_launch(1'b0, 1'b0);
    n_checks++;
    if (ob_halt_k != 20 || ob_cause !== 2'b01 || ob_cyc !== 32'd20 || ob_icnt !== 32'd21) begin
      n_fail++; $display("FAIL ecall_halt: got k=%0d cause=%b cyc=%0d icnt=%0d want k=20 cause=01 cyc=20 icnt=21",
                         ob_halt_k, ob_cause, ob_cyc, ob_icnt);
    end
    n_checks++;
    if (!ob_frz_ok) begin
      n_fail++; $display("FAIL ecall_freeze: got frz_ok=%0d want 1", ob_frz_ok);
    end
  endtask

  task automatic test_self_loop();
    sel = 1'b0; #1;
    gen_case(-1, 1'b0, 10, 32'h40, 1'b0); model(500); run_launch(1'b0, 1'b0);
    n_checks++;
    if (ob_cause !== 2'b10 || ob_cyc !== 32'd17 || ob_halt_k != exp_k) begin
      n_fail++; $display("FAIL loop_halt: got k=%0d cause=%b cyc=%0d want k=%0d cause=10 cyc=17",
                         ob_halt_k, ob_cause, ob_cyc, exp_k);
    end
    n_checks++;
    if (ob_icnt !== exp_icnt) begin
      n_fail++; $display("FAIL loop_icnt: got %0d want %0d", ob_icnt, exp_icnt);
    end
  endtask

  task automatic test_priority();
    sel = 1'b1; #1;
    gen_case(19, 1'b1, 12, 32'h40, 1'b1); model(20); run_launch(1'b0, 1'b0);
    n_checks++;
    if (ob_halt_k != 19 || ob_cause !== 2'b01 || ob_cyc !== 32'd19 || ob_icnt !== 32'd20) begin
      n_fail++; $display("FAIL priority_halt: got k=%0d cause=%b cyc=%0d icnt=%0d want k=19 cause=01 cyc=19 icnt=20",
                         ob_halt_k, ob_cause, ob_cyc, ob_icnt);
    end
    sel = 1'b0; #1;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; #1;
    gen_case(int'($urandom_range(5, 30)), 1'b0, -1, 32'h0, 1'b0); model(500); run_launch(1'b0, 1'b1);
    n_checks++;
    if (ob_rst_len != RSTC || ob_halt_k != exp_k || ob_cause !== exp_cause || ob_icnt !== exp_icnt || !ob_cnt_ok) begin
      n_fail++; $display("FAIL ignored_start: got rst_len=%0d k=%0d cause=%b icnt=%0d cnt_ok=%0d want %0d %0d %b %0d 1",
                         ob_rst_len, ob_halt_k, ob_cause, ob_icnt, ob_cnt_ok, RSTC, exp_k, exp_cause, exp_icnt);
    end
    gen_case(int'($urandom_range(2, 40)), 1'b1, -1, 32'h0, 1'b0); model(500); run_launch(1'b0, 1'b0);
    n_checks++;
    if (ob0_done !== 1'b0 || ob0_cause !== 2'b00 || ob0_busy !== 1'b1 || ob0_cyc !== 32'd0 || ob0_icnt !== 32'd0) begin
      n_fail++; $display("FAIL relaunch_clear: got done=%b cause=%b busy=%b cyc=%0d icnt=%0d want 0 00 1 0 0",
                         ob0_done, ob0_cause, ob0_busy, ob0_cyc, ob0_icnt);
    end
    n_checks++;
    if (ob_rst_len != RSTC || ob_halt_k != exp_k || ob_cause !== exp_cause || ob_icnt !== exp_icnt) begin
      n_fail++; $display("FAIL relaunch_run: got rst_len=%0d k=%0d cause=%b icnt=%0d want %0d %0d %b %0d",
                         ob_rst_len, ob_halt_k, ob_cause, ob_icnt, RSTC, exp_k, exp_cause, exp_icnt);
    end
  endtask

  task automatic test_rst_mid_run();
    sel = 1'b0; #1;
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
    for (int i = 0; i < RSTC + 10; i++) begin
      pc_drv = 32'h2000 + 32'(4 * i); instr_drv = 32'h0000_0013; vld_drv = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy_a !== 1'b1 || bus_a.core_rst !== 1'b0 || cyc_a !== 9'd10) begin
      n_fail++; $display("FAIL midrun_pre: got busy=%b core_rst=%b cyc=%0d want 1 0 10", busy_a, bus_a.core_rst, cyc_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.core_rst, busy_a, done_a, cause_a} !== 5'b10000 || cyc_a !== 9'd0 || icnt_a !== 32'd0) begin
      n_fail++; $display("FAIL midrun_async: got rst=%b busy=%b done=%b cause=%b cyc=%0d icnt=%0d want 1 0 0 00 0 0",
                         bus_a.core_rst, busy_a, done_a, cause_a, cyc_a, icnt_a);
    end
    vld_drv = 1'b0;
    start_a = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    gen_case(int'($urandom_range(3, 40)), 1'b0, -1, 32'h0, 1'b0); model(500); run_launch(1'b1, 1'b0);
    n_checks++;
    if (ob0_busy !== 1'b1 || ob0_cyc !== 32'd0 || ob0_icnt !== 32'd0) begin
      n_fail++; $display("FAIL midrun_start_on_release: got busy=%b cyc=%0d icnt=%0d want 1 0 0", ob0_busy, ob0_cyc, ob0_icnt);
    end
    n_checks++;
    if (ob_rst_len != RSTC || ob_halt_k != exp_k || ob_cause !== 2'b01 || ob_icnt !== exp_icnt || !ob_cnt_ok) begin
      n_fail++; $display("FAIL midrun_relaunch: got rst_len=%0d k=%0d cause=%b icnt=%0d cnt_ok=%0d want %0d %0d 01 %0d 1",
                         ob_rst_len, ob_halt_k, ob_cause, ob_icnt, ob_cnt_ok, RSTC, exp_k, exp_icnt);
    end
  endtask

  task automatic test_random();
    int maxc, sys_at, hold_from;
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom_range(0, 1)); #1;
      maxc      = sel ? 20 : 500;
      sys_at    = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, sel ? 25 : 120));
      hold_from = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, sel ? 25 : 120));
      gen_case(sys_at, 1'($urandom_range(0, 1)), hold_from, {$urandom, 2'b00} >> 2 << 2,
               1'($urandom_range(0, 1)));
      model(maxc);
      run_launch(1'b0, 1'b0);
      n_checks++;
      if (ob_rst_len != RSTC || ob_halt_k != exp_k || ob_cause !== exp_cause ||
          ob_cyc !== 32'(exp_k) || ob_icnt !== exp_icnt || !ob_cnt_ok || !ob_frz_ok) begin
        n_fail++; $display("FAIL random[%0d] sel=%0d: got rst_len=%0d k=%0d cause=%b cyc=%0d icnt=%0d cnt_ok=%0d frz_ok=%0d want %0d %0d %b %0d %0d 1 1",
                           it, sel, ob_rst_len, ob_halt_k, ob_cause, ob_cyc, ob_icnt, ob_cnt_ok, ob_frz_ok,
                           RSTC, exp_k, exp_cause, exp_k, exp_icnt);
      end
    end
    sel = 1'b0; #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_timeout();
    test_ecall();
    test_self_loop();
    test_priority();
    test_back_to_back();
    test_rst_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rv32i_run_ctrl.md
RV32I_RUN_CTRL -- requirements
Module: rv32i_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 4: number of cycles core_rst is held high after each start; legal range 1..255.
REQ-002 Parameter MAX_CYCLES, default 500: RUN-state cycle budget before a timeout halt; legal range 2..2^20.
REQ-003 Parameter STALL_LIMIT, default 8: consecutive cycles with an unchanged pc that declare a self-loop halt; legal range 2..255.
REQ-004 Parameter CW, default $clog2(MAX_CYCLES+1): width of cycle_count.
REQ-005 clk  in  1  single system clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle launch request.
REQ-008 pc  in  32  current program counter of the controlled rv32i core.
REQ-009 instr  in  32  instruction retiring this cycle.
REQ-010 instr_valid  in  1  instr is valid and retires this cycle.
REQ-011 core_rst  out  1  active-high reset driven to the rv32i core.
REQ-012 busy  out  1  high in the RESET and RUN states.
REQ-013 done  out  1  high in the DONE state.
REQ-014 halt_cause  out  2  00 none, 01 ecall/ebreak, 10 pc self-loop, 11 timeout.
REQ-015 cycle_count  out  CW  RUN cycles elapsed in the current launch.
REQ-016 instr_count  out  32  instructions retired in the current launch.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, RESET, RUN, DONE.
REQ-018 In IDLE: core_rst=1, busy=0, done=0; start=1 SHALL move to RESET on the next edge and clear cycle_count, instr_count, halt_cause and the stall counter.
REQ-019 In RESET: core_rst=1, busy=1; an internal counter SHALL advance to RUN after exactly RST_CYCLES cycles in RESET.
REQ-020 In RUN: core_rst=0, busy=1; cycle_count SHALL increment every cycle; instr_count SHALL increment on each instr_valid, saturating at 32'hFFFFFFFF.
REQ-021 ecall/ebreak halt: instr_valid=1 with instr==32'h00000073 or 32'h00100073 in RUN SHALL move to DONE with halt_cause=01; that instruction SHALL be counted in instr_count.
REQ-022 Self-loop halt: a stall counter SHALL increment when pc equals the pc registered on the previous RUN cycle and SHALL clear otherwise; reaching STALL_LIMIT SHALL move to DONE with halt_cause=10.
REQ-023 The first RUN cycle SHALL NOT be compared against any pc sampled in RESET.
REQ-024 Timeout halt: a RUN cycle in which cycle_count equals MAX_CYCLES-1 SHALL move to DONE with halt_cause=11.
REQ-025 When several halt conditions hold in the same cycle, priority SHALL be 01 > 10 > 11.
REQ-026 done and halt_cause SHALL update on the edge that ends the detecting cycle (1-cycle latency); counters SHALL freeze in DONE.
REQ-027 In DONE: core_rst=1, busy=0, done=1, and all outputs SHALL hold until start.
REQ-028 start in DONE SHALL relaunch exactly as from IDLE (REQ-018); start in RESET or RUN SHALL be ignored.
REQ-029 cycle_count SHALL never wrap; timeout is always reached before overflow.

Reset
REQ-030 While rst=0: state=IDLE, core_rst=1, busy=0, done=0, halt_cause=00, cycle_count=0, instr_count=0, all internal counters 0, regardless of clk.
REQ-031 rst asserted mid-RUN SHALL immediately force core_rst=1 and return to IDLE; no partial halt_cause SHALL survive.
REQ-032 Deassertion of rst SHALL take effect on the first clk edge after release; start sampled on that edge SHALL be honoured.

Verification
REQ-033 Defaults; start pulse, pc incrementing by 4, no ecall -> core_rst high for 4 cycles, then RUN; done=1, halt_cause=11, cycle_count=499 at DONE.
REQ-034 ecall retires on RUN cycle 20 with instr_valid every cycle -> done=1 on the next edge, halt_cause=01, instr_count=21, cycle_count=20.
REQ-035 pc held at 32'h40 from RUN cycle 10 -> halt_cause=10 after 8 matching cycles; cycle_count=17.
REQ-036 ebreak retires in the cycle that also completes the stall limit and the timeout (MAX_CYCLES=20) -> halt_cause=01.
REQ-037 rst pulsed low mid-RUN, then start -> outputs at reset values immediately; relaunch gives fresh counts from 0 and RST_CYCLES of core_rst.
REQ-038 start pulsed during RESET and RUN; then start in DONE -> first two ignored; the third relaunches and clears done and halt_cause.
